player_health_manager: RTL and testbench

Authoritative round-state and health bookkeeping for both players, sitting directly upstream of `display_character_and_health`. Consumes single-cycle hit pulses from projectile collision and the `p1_clear_ult`/`p2_clear_ult` ultimate-fired pulses coming back from the display stage. Produces the packed 12-bit `health_data` word, per-player invulnerability flags and game-over/winner status. Runs a small round FSM: IDLE, PLAYING, OVER.

---
 rtl/game_pkg.sv | 30 +++
 rtl/player_health_tracker.sv | 57 +++++
 rtl/player_health_manager.sv | 91 +++++++++
 tb/tb_player_health_manager.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared round-state encodings, character/winner codes and health_data layout
//   Also used by display_character_and_health to unpack health_data.
package game_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, PLAYING = 2'd1, OVER = 2'd2} state_t;
    typedef enum logic [1:0] {CHAR_MAGE = 2'd0, CHAR_GUNMAN = 2'd1, CHAR_SWORDMAN = 2'd2, CHAR_FISTMAN = 2'd3} char_t;
    localparam logic [1:0] WIN_NONE = 2'd0;
    localparam logic [1:0] WIN_P1   = 2'd1;
    localparam logic [1:0] WIN_P2   = 2'd2;
    localparam logic [1:0] WIN_DRAW = 2'd3;
    localparam int HEALTH_W      = 4;
    localparam int CHAR_W        = 2;
    localparam int HDATA_W       = 2 * (HEALTH_W + CHAR_W);
    localparam int P2_HEALTH_LSB = 0;
    localparam int P2_CHAR_LSB   = P2_HEALTH_LSB + HEALTH_W;
    localparam int P1_HEALTH_LSB = P2_CHAR_LSB + CHAR_W;
    localparam int P1_CHAR_LSB   = P1_HEALTH_LSB + HEALTH_W;

    function automatic logic [HDATA_W-1:0] pack_health(
        input logic [CHAR_W-1:0]   c1,
        input logic [HEALTH_W-1:0] h1,
        input logic [CHAR_W-1:0]   c2,
        input logic [HEALTH_W-1:0] h2
    );
        pack_health = '0;
        pack_health[P1_CHAR_LSB +: CHAR_W]     = c1;
        pack_health[P1_HEALTH_LSB +: HEALTH_W] = h1;
        pack_health[P2_CHAR_LSB +: CHAR_W]     = c2;
        pack_health[P2_HEALTH_LSB +: HEALTH_W] = h2;
    endfunction
endpackage

// File: rtl/player_health_tracker.sv
// player_health_tracker: one player's health register, saturating damage and invulnerability counter
//   clk, reset (async, active-low)
//   hit         : projectile struck this player (ignored while invulnerable)
//   opp_ult     : opponent fired an ultimate (always applied)
//   load        : reload health to MAX_HEALTH and clear the counter
//   enable      : round in progress; damage is applied only while high
//   health      : registered health
//   health_next : value health takes on the next edge (lets the top detect game over with no lag)
//   invuln      : invulnerability window active
module player_health_tracker
    import game_pkg::*;
#(
    parameter int MAX_HEALTH    = 10,
    parameter int HIT_DAMAGE    = 1,
    parameter int ULT_DAMAGE    = 3,
    parameter int INVULN_CYCLES = 50_000_000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                hit,
    input  logic                opp_ult,
    input  logic                load,
    input  logic                enable,
    output logic [HEALTH_W-1:0] health,
    output logic [HEALTH_W-1:0] health_next,
    output logic                invuln
);
    localparam int DW = HEALTH_W + 2;
    localparam int CW = $clog2(INVULN_CYCLES);

    logic [DW-1:0] dmg;
    logic [CW-1:0] count;

    assign invuln = count != '0;

    // Damage is summed wide so a hit plus an ult can never wrap before the saturating compare.
    always_comb begin
        dmg = (hit && !invuln ? DW'(HIT_DAMAGE) : DW'(0)) + (opp_ult ? DW'(ULT_DAMAGE) : DW'(0));
        health_next = load ? HEALTH_W'(MAX_HEALTH)
                    : !enable ? health
                    : ({2'b00, health} > dmg) ? health - dmg[HEALTH_W-1:0]
                    : '0;
    end

    // The counter keeps draining outside PLAYING; any damage restarts the full window.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            health <= HEALTH_W'(MAX_HEALTH);
            count  <= '0;
        end else begin
            health <= health_next;
            count  <= load ? '0
                    : (enable && dmg != '0) ? CW'(INVULN_CYCLES - 1)
                    : count - CW'(invuln);
        end
    end
endmodule

// File: rtl/player_health_manager.sv
// player_health_manager: round FSM and health bookkeeping for both players
//   clk, reset (async, active-low)
//   start                       : begins a round from IDLE or OVER (ignored while PLAYING)
//   p1_char_sel, p2_char_sel    : character selects, followed in IDLE, latched on start
//   p1_hit, p2_hit              : projectile struck that player
//   p1_clear_ult, p2_clear_ult  : that player fired an ultimate, damaging the opponent
//   health_data                 : {p1_char, p1_health, p2_char, p2_health}
//   p1_invuln, p2_invuln        : invulnerability windows
//   game_over, winner           : round finished and who won (00 none, 01 P1, 10 P2, 11 draw)
module player_health_manager
    import game_pkg::*;
#(
    parameter int MAX_HEALTH    = 10,
    parameter int HIT_DAMAGE    = 1,
    parameter int ULT_DAMAGE    = 3,
    parameter int INVULN_CYCLES = 50_000_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [CHAR_W-1:0]  p1_char_sel,
    input  logic [CHAR_W-1:0]  p2_char_sel,
    input  logic               p1_hit,
    input  logic               p2_hit,
    input  logic               p1_clear_ult,
    input  logic               p2_clear_ult,
    output logic [HDATA_W-1:0] health_data,
    output logic               p1_invuln,
    output logic               p2_invuln,
    output logic               game_over,
    output logic [1:0]         winner
);
    state_t state, state_next;
    logic [CHAR_W-1:0] p1_char, p2_char, p1_char_next, p2_char_next;
    logic [1:0] winner_next;
    logic [HEALTH_W-1:0] p1_health, p2_health, p1_health_next, p2_health_next;
    logic load, enable;

    assign load   = start && state != PLAYING;
    assign enable = state == PLAYING;

    player_health_tracker #(
        .MAX_HEALTH(MAX_HEALTH), .HIT_DAMAGE(HIT_DAMAGE),
        .ULT_DAMAGE(ULT_DAMAGE), .INVULN_CYCLES(INVULN_CYCLES)
    ) u_p1 (
        .clk(clk), .reset(reset), .hit(p1_hit), .opp_ult(p2_clear_ult),
        .load(load), .enable(enable), .health(p1_health),
        .health_next(p1_health_next), .invuln(p1_invuln)
    );

    player_health_tracker #(
        .MAX_HEALTH(MAX_HEALTH), .HIT_DAMAGE(HIT_DAMAGE),
        .ULT_DAMAGE(ULT_DAMAGE), .INVULN_CYCLES(INVULN_CYCLES)
    ) u_p2 (
        .clk(clk), .reset(reset), .hit(p2_hit), .opp_ult(p1_clear_ult),
        .load(load), .enable(enable), .health(p2_health),
        .health_next(p2_health_next), .invuln(p2_invuln)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            p1_char <= CHAR_MAGE;
            p2_char <= CHAR_MAGE;
            winner  <= WIN_NONE;
        end else begin
            state   <= state_next;
            p1_char <= p1_char_next;
            p2_char <= p2_char_next;
            winner  <= winner_next;
        end
    end

    // Game over is decided from next-cycle healths so it lands on the same edge as the killing blow.
    always_comb begin
        state_next   = state;
        winner_next  = winner;
        p1_char_next = (load || state == IDLE) ? p1_char_sel : p1_char;
        p2_char_next = (load || state == IDLE) ? p2_char_sel : p2_char;
        if (load) begin
            state_next  = PLAYING;
            winner_next = WIN_NONE;
        end else if (enable && (p1_health_next == '0 || p2_health_next == '0)) begin
            state_next  = OVER;
            winner_next = (p1_health_next == '0) ? ((p2_health_next == '0) ? WIN_DRAW : WIN_P2) : WIN_P1;
        end
    end

    assign game_over   = state == OVER;
    assign health_data = pack_health(p1_char, p1_health, p2_char, p2_health);
endmodule

// File: tb/tb_player_health_manager.sv
// tb_player_health_manager: directed test-plan steps plus random pulses against a behavioural model
module tb_player_health_manager;
    localparam int MAXH = 10;
    localparam int HD   = 1;
    localparam int UD   = 3;
    localparam int INV  = 8;

    logic clk = 0, reset = 1, start = 0;
    logic p1_hit = 0, p2_hit = 0, p1_clear_ult = 0, p2_clear_ult = 0;
    logic [1:0] p1_char_sel = 0, p2_char_sel = 0;
    logic [11:0] health_data;
    logic p1_invuln, p2_invuln, game_over;
    logic [1:0] winner;

    int n_assert = 0;
    int n_fail = 0;

    // model: 0 idle, 1 playing, 2 over; invulnerability as "edge of last damage"
    int m_state, m_win;
    int m_h[2];
    int m_ch[2];
    longint m_last[2];
    longint m_edge = 0;

    always #5 clk = ~clk;

    player_health_manager #(
        .MAX_HEALTH(MAXH), .HIT_DAMAGE(HD), .ULT_DAMAGE(UD), .INVULN_CYCLES(INV)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .p1_char_sel(p1_char_sel), .p2_char_sel(p2_char_sel),
        .p1_hit(p1_hit), .p2_hit(p2_hit),
        .p1_clear_ult(p1_clear_ult), .p2_clear_ult(p2_clear_ult),
        .health_data(health_data), .p1_invuln(p1_invuln), .p2_invuln(p2_invuln),
        .game_over(game_over), .winner(winner)
    );

    // invulnerable for INV-1 edges after the edge that applied damage
    function automatic bit m_inv(int x);
        return (m_edge - m_last[x]) < INV - 1;
    endfunction

    function automatic void model_reset();
        m_state = 0;
        m_win = 0;
        m_h = '{MAXH, MAXH};
        m_ch = '{0, 0};
        m_last = '{-100, -100};
    endfunction

    function automatic void model_step(bit h1, bit h2, bit u1, bit u2, bit st, int s1, int s2);
        int dmg[2];
        if (m_state == 1) begin
            dmg[0] = ((h1 && !m_inv(0)) ? HD : 0) + (u2 ? UD : 0);
            dmg[1] = ((h2 && !m_inv(1)) ? HD : 0) + (u1 ? UD : 0);
            for (int x = 0; x < 2; x++)
                if (dmg[x] > 0) begin
                    m_h[x] = (m_h[x] - dmg[x] < 0) ? 0 : m_h[x] - dmg[x];
                    m_last[x] = m_edge + 1;
                end
            if (m_h[0] == 0 || m_h[1] == 0) begin
                m_state = 2;
                m_win = (m_h[0] == 0 && m_h[1] == 0) ? 3 : (m_h[0] == 0) ? 2 : 1;
            end
        end else if (st) begin
            m_state = 1;
            m_win = 0;
            m_ch = '{s1, s2};
            m_h = '{MAXH, MAXH};
            m_last = '{-100, -100};
        end else if (m_state == 0) begin
            m_ch = '{s1, s2};
        end
        m_edge++;
    endfunction

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ":health_data"}, health_data, 12'(m_ch[0] * 1024 + m_h[0] * 64 + m_ch[1] * 16 + m_h[1]));
        chk({tag, ":p1_invuln"}, 12'(p1_invuln), 12'(m_inv(0)));
        chk({tag, ":p2_invuln"}, 12'(p2_invuln), 12'(m_inv(1)));
        chk({tag, ":game_over"}, 12'(game_over), 12'(m_state == 2));
        chk({tag, ":winner"}, 12'(winner), 12'(m_win));
    endtask

    task automatic tick(input string tag, input bit h1, input bit h2, input bit u1, input bit u2, input bit st);
        p1_hit = h1;
        p2_hit = h2;
        p1_clear_ult = u1;
        p2_clear_ult = u2;
        start = st;
        @(posedge clk);
        model_step(h1, h2, u1, u2, st, int'(p1_char_sel), int'(p2_char_sel));
        #1;
        check_all(tag);
        p1_hit = 0;
        p2_hit = 0;
        p1_clear_ult = 0;
        p2_clear_ult = 0;
        start = 0;
    endtask

    initial begin
        #1 reset = 0;
        #2;
        model_reset();
        check_all("reset");
        chk("reset_hd", health_data, 12'h28A);
        @(negedge clk) reset = 1;

        // round start with latched characters
        p1_char_sel = 2'd1;
        p2_char_sel = 2'd2;
        tick("idle_follow", 0, 0, 0, 0, 0);
        tick("start", 0, 0, 0, 0, 1);
        chk("t1_hd", health_data, 12'h6AA);
        chk("t1_go", 12'(game_over), 12'h0);

        // invulnerability window and its boundary
        tick("hit1", 0, 1, 0, 0, 0);
        chk("t2_p2h_first", 12'(health_data[3:0]), 12'd9);
        chk("t2_p2inv", 12'(p2_invuln), 12'h1);
        repeat (2) tick("gap", 0, 0, 0, 0, 0);
        tick("hit2", 0, 1, 0, 0, 0);
        chk("t2_p2h_ignored", 12'(health_data[3:0]), 12'd9);
        repeat (3) tick("gap", 0, 0, 0, 0, 0);
        tick("hit_edge7", 0, 1, 0, 0, 0);
        chk("t2_p2h_edge7", 12'(health_data[3:0]), 12'd9);
        tick("hit_edge8", 0, 1, 0, 0, 0);
        chk("t2_p2h_accepted", 12'(health_data[3:0]), 12'd8);

        // ult bypasses invulnerability and ends the round
        tick("start_ignored", 0, 0, 0, 0, 1);
        tick("ult_a", 0, 0, 1, 0, 0);
        tick("ult_b", 0, 0, 1, 0, 0);
        chk("t3_p2inv", 12'(p2_invuln), 12'h1);
        chk("t3_p2h", 12'(health_data[3:0]), 12'd2);
        tick("ult_kill", 0, 0, 1, 0, 0);
        chk("t3_win", 12'(winner), 12'h1);
        chk("t3_go", 12'(game_over), 12'h1);
        tick("over_frozen", 1, 1, 1, 1, 0);
        chk("t3_frozen", health_data, 12'h6A0);

        // restart from OVER with P1 at 7 and new characters
        tick("restart", 0, 0, 0, 0, 1);
        tick("both_ult", 0, 0, 1, 1, 0);
        repeat (3) tick("p1_ults", 0, 0, 1, 0, 0);
        chk("t5_p1h", 12'(health_data[9:6]), 12'd7);
        p1_char_sel = 2'd3;
        p2_char_sel = 2'd0;
        tick("restart2", 0, 0, 0, 0, 1);
        chk("t5_hd", health_data, 12'hE8A);
        chk("t5_win", 12'(winner), 12'h0);

        // draw
        repeat (3) tick("both_ult", 0, 0, 1, 1, 0);
        repeat (8) tick("drain", 0, 0, 0, 0, 0);
        tick("double_hit", 1, 1, 0, 0, 0);
        chk("t4_win", 12'(winner), 12'h3);
        chk("t4_hd", health_data, 12'hC00);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(7) == 0) begin
                p1_char_sel = 2'($urandom_range(3));
                p2_char_sel = 2'($urandom_range(3));
            end
            tick("rand", $urandom_range(3) == 0, $urandom_range(3) == 0,
                 $urandom_range(11) == 0, $urandom_range(11) == 0, $urandom_range(24) == 0);
        end

        // asynchronous reset mid-round
        if (m_state != 1) tick("pre_rst_start", 0, 0, 0, 0, 1);
        tick("pre_rst_hit", 1, 0, 0, 0, 0);
        #2 reset = 0;
        #1;
        model_reset();
        check_all("async_rst");
        chk("async_rst_hd", health_data, 12'h28A);
        @(negedge clk) reset = 1;
        tick("post_rst_idle", 1, 1, 1, 1, 0);
        tick("post_rst_start", 0, 0, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
